// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock through a small
// ripple slice, publishing sum/cout/ovf together when the last chunk completes.

module serial_adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             c_msb,
    output logic             co
);
    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    // carry into the chunk's top bit feeds the signed-overflow detect
    assign c_msb = c[CHUNK-1];
    assign co    = c[CHUNK];
endmodule

module serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] opa, opb, acc, acc_nx;
    logic             carry;
    logic [KW-1:0]    k;
    logic [CHUNK-1:0] xa, xb, cs;
    logic             c_msb, c_out;

    // shifts instead of indexed part-selects keep the CHUNK==WIDTH case in range
    always_comb begin
        xa     = CHUNK'(opa >> (int'(k) * CHUNK));
        xb     = CHUNK'(opb >> (int'(k) * CHUNK));
        acc_nx = acc | (WIDTH'(cs) << (int'(k) * CHUNK));
    end

    serial_adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x     (xa),
        .y     (xb),
        .ci    (carry),
        .s     (cs),
        .c_msb (c_msb),
        .co    (c_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            k     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // subtraction as a + ~b + ~cin
                        opa   <= a;
                        opb   <= b ^ {WIDTH{sub}};
                        carry <= cin ^ sub;
                        acc   <= '0;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc   <= acc_nx;
                    carry <= c_out;
                    if (k == KW'(NCH - 1)) begin
                        k     <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= acc_nx;
                        cout  <= c_out;
                        ovf   <= c_msb ^ c_out;
                        state <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed table for the 16/4 adder, back-to-back and reset-abort sequences,
// and exhaustive 4-bit runs against plain integer arithmetic for CHUNK=1,2,4.

module tb_serial_adder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, sub, cin;
    logic [15:0] a, b;
    logic        busy, done, cout, ovf;
    logic [15:0] sum;

    logic [2:0]      w4_start, w4_sub, w4_cin, w4_busy, w4_done, w4_cout, w4_ovf;
    logic [2:0][3:0] w4_a, w4_b, w4_sum;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    serial_adder #(.WIDTH(4), .CHUNK(1)) dut_c1 (
        .clk(clk), .rst_n(rst_n), .start(w4_start[0]), .sub(w4_sub[0]), .a(w4_a[0]),
        .b(w4_b[0]), .cin(w4_cin[0]), .busy(w4_busy[0]), .done(w4_done[0]),
        .sum(w4_sum[0]), .cout(w4_cout[0]), .ovf(w4_ovf[0])
    );

    serial_adder #(.WIDTH(4), .CHUNK(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .start(w4_start[1]), .sub(w4_sub[1]), .a(w4_a[1]),
        .b(w4_b[1]), .cin(w4_cin[1]), .busy(w4_busy[1]), .done(w4_done[1]),
        .sum(w4_sum[1]), .cout(w4_cout[1]), .ovf(w4_ovf[1])
    );

    serial_adder #(.WIDTH(4), .CHUNK(4)) dut_c4 (
        .clk(clk), .rst_n(rst_n), .start(w4_start[2]), .sub(w4_sub[2]), .a(w4_a[2]),
        .b(w4_b[2]), .cin(w4_cin[2]), .busy(w4_busy[2]), .done(w4_done[2]),
        .sum(w4_sum[2]), .cout(w4_cout[2]), .ovf(w4_ovf[2])
    );

    typedef struct {
        logic        sub;
        logic [15:0] a, b;
        logic        cin;
        logic [15:0] sum;
        logic        cout, ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic op16(input vec_t v, input int idx);
        int n, bcnt, both;
        @(negedge clk);
        start = 1'b1; sub = v.sub; a = v.a; b = v.b; cin = v.cin;
        @(negedge clk);
        // scramble inputs: the operation must run on latched values
        start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; sub = ~v.sub; cin = ~v.cin;
        n = 0; bcnt = busy ? 1 : 0; both = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (busy) bcnt++;
            if (busy && done) both++;
        end
        chk($sformatf("v%0d_latency", idx), n, 4);
        chk($sformatf("v%0d_busy_cycles", idx), bcnt, 4);
        chk($sformatf("v%0d_busy_done_overlap", idx), both, 0);
        chk($sformatf("v%0d_result", idx), {sum, cout, ovf}, {v.sum, v.cout, v.ovf});
    endtask

    task automatic op4(input int idx, input int nch, input logic s, input logic [3:0] x,
                       input logic [3:0] y, input logic ci);
        int ux, uy, sx, sy, r, sv, n;
        logic [3:0] es;
        logic ec, eo;
        ux = x; uy = y;
        sx = x[3] ? ux - 16 : ux;
        sy = y[3] ? uy - 16 : uy;
        if (!s) begin
            r  = ux + uy + ci;
            ec = (r > 15);
            sv = sx + sy + ci;
        end else begin
            r  = ux - uy - ci;
            ec = (r >= 0);
            sv = sx - sy - ci;
        end
        es = r[3:0];
        eo = (sv > 7) || (sv < -8);
        @(negedge clk);
        w4_start[idx] = 1'b1; w4_sub[idx] = s; w4_a[idx] = x; w4_b[idx] = y; w4_cin[idx] = ci;
        @(negedge clk);
        w4_start[idx] = 1'b0;
        n = 0;
        while (!w4_done[idx] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("w4_chunkcfg%0d_s%0d_a%0h_b%0h_c%0d", idx, s, x, y, ci),
            {n[7:0], w4_sum[idx], w4_cout[idx], w4_ovf[idx]}, {nch[7:0], es, ec, eo});
    endtask

    initial begin
        logic [15:0] ba[3], bb[3], bs[3], prev;
        int n, last, held_bad, seen_done;

        vecs[0] = '{1'b0, 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 16'h1000, 16'h0001, 1'b1, 16'h0FFE, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[9] = '{1'b0, 16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        w4_start = '0; w4_sub = '0; w4_cin = '0; w4_a = '0; w4_b = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {busy, done, sum, cout, ovf}, '0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) op16(vecs[i], i);

        // result must hold while idle
        repeat (3) @(negedge clk);
        chk("idle_hold", {sum, cout, ovf, done, busy}, {16'h0100, 3'b000, 1'b0});

        // start held high: a result every NCH+1 cycles, mid-run inputs ignored
        ba = '{16'h0001, 16'h00FF, 16'h7000};
        bb = '{16'h0002, 16'h0001, 16'h1000};
        bs = '{16'h0003, 16'h0100, 16'h8000};
        prev = sum; held_bad = 0; last = 0;
        @(negedge clk);
        start = 1'b1; sub = 1'b0; cin = 1'b0; a = ba[0]; b = bb[0];
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom);
            n = 0;
            while (!done && n < 20) begin
                if (sum !== prev) held_bad++;
                @(negedge clk);
                n++;
            end
            chk($sformatf("b2b%0d_latency", i), n, 4);
            chk($sformatf("b2b%0d_sum", i), sum, bs[i]);
            if (i > 0) chk($sformatf("b2b%0d_period", i), cyc - last, 5);
            last = cyc;
            prev = bs[i];
            if (i < 2) begin a = ba[i+1]; b = bb[i+1]; end
            else start = 1'b0;
        end
        chk("b2b_sum_held_during_run", held_bad, 0);
        chk("b2b_last_ovf", {cout, ovf}, 2'b01);

        // reset on the second RUN cycle aborts the operation
        @(negedge clk);
        start = 1'b1; a = 16'h1111; b = 16'h1111; sub = 1'b0; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs_cleared", {busy, done, sum, cout, ovf}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        chk("abort_no_done", seen_done, 0);
        op16(vecs[4], 40);

        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    for (int c = 0; c < 2; c++) begin
                        op4(0, 4, s[0], x[3:0], y[3:0], c[0]);
                        op4(1, 2, s[0], x[3:0], y[3:0], c[0]);
                        op4(2, 1, s[0], x[3:0], y[3:0], c[0]);
                    end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits added per clock; WIDTH % CHUNK == 0 and 1 <= CHUNK <= WIDTH; NCH = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE or DONE.
REQ-006 SHALL have port sub  input  1  mode, latched with start: 0 = a+b+cin, 1 = a-b-cin.
REQ-007 SHALL have port a  input  WIDTH  first operand, latched with start.
REQ-008 SHALL have port b  input  WIDTH  second operand, latched with start.
REQ-009 SHALL have port cin  input  1  carry-in (add) / borrow-in (sub), latched with start.
REQ-010 SHALL have port busy  output  1  high while in RUN.
REQ-011 SHALL have port done  output  1  one-cycle pulse, high only in DONE.
REQ-012 SHALL have port sum  output  WIDTH  result.
REQ-013 SHALL have port cout  output  1  carry out of bit WIDTH-1 (sub: 1 = no borrow).
REQ-014 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE.
REQ-016 IDLE: start=1 at an edge SHALL latch a, b^{WIDTH{sub}}, carry=cin^sub, chunk index k=0; go to RUN.
REQ-017 RUN: each edge SHALL add chunk k of both latched operands plus the carry register (CHUNK-bit ripple), store the CHUNK result bits at position k, update carry, increment k.
REQ-018 RUN SHALL last exactly NCH cycles; the edge processing chunk NCH-1 SHALL enter DONE.
REQ-019 On entering DONE, sum, cout and ovf SHALL update together; ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-020 sum/cout/ovf SHALL hold their values at all other times, including during a following RUN.
REQ-021 Latency: start sampled at edge t -> done high in the cycle after edge t+NCH; busy high in the cycles after edges t..t+NCH-1.
REQ-022 DONE lasts one cycle: start=1 SHALL go directly to RUN (latching new operands); otherwise IDLE. Back-to-back throughput is NCH+1 cycles per operation.
REQ-023 start in RUN SHALL be ignored; operands and mode SHALL not change mid-operation.
REQ-024 Chunk index SHALL not wrap past NCH-1; CHUNK=WIDTH SHALL give one RUN cycle.
REQ-025 busy and done SHALL never be high together.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, k=0, carry=0, busy=0, done=0, sum=0, cout=0, ovf=0.
REQ-027 Reset during RUN SHALL abort: no done pulse and no output update for the aborted operation.
REQ-028 After rst_n rises, the first edge SHALL accept start normally.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-029 add 0x0001+0xFFFF, cin=0, start at edge t -> busy for 4 cycles, done in the cycle after edge t+4, sum=0x0000, cout=1, ovf=0.
REQ-030 add 0x7FFF+0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
REQ-031 sub 0x0005-0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0; sub 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
REQ-032 start held high continuously with new operands each DONE -> results every 5 cycles; start pulses during RUN ignored; sum unchanged until each DONE.
REQ-033 rst_n low on the 2nd RUN cycle -> busy, done, sum, cout and ovf 0 immediately; no done follows; the next start completes correctly.
REQ-034 WIDTH=4 with CHUNK=1, 2 and 4: exhaustive a, b, cin, sub (1024 cases) -> sum/cout/ovf match the reference arithmetic; latency NCH+1.
